sort_job_scheduler: RTL and testbench
=====================================

# sort_job_scheduler

Job scheduler that sits in front of one `sort_circuit` instance and sequences it. It queues sort requests (array sizes) in a small FIFO, validates each one, and launches the sorter with a one-cycle start pulse. It then waits for done/err under an optional watchdog and returns one tagged result per job through a valid/ready response port.

## Interface
Parameters:
- `ADDR_WDTH`, 4: sorter address width; valid sizes are 1..2^ADDR_WDTH
- `FIFO_LOG2`, 2: job FIFO depth = 2^FIFO_LOG2
- `ID_WDTH`, 4: job tag width
- `TMO_WDTH`, 16: watchdog counter width

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `job_valid` in 1: job offered
- `job_size` in ADDR_WDTH+1: requested array size
- `job_ready` out 1: FIFO not full and not halted
- `sort_arr_size` out ADDR_WDTH+1: size driven to sorter
- `sort_start` out 1: one-cycle launch pulse
- `sort_done` in 1: sorter finished
- `sort_err` in 1: sorter error, qualified by `sort_done`
- `tmo_limit` in TMO_WDTH: watchdog limit in cycles; 0 disables the watchdog
- `res_valid` out 1: result available
- `res_ready` in 1: result consumed
- `res_id` out ID_WDTH: tag of the finished job
- `res_status` out 2: 00 ok, 01 sort error, 10 timeout, 11 rejected
- `pending` out FIFO_LOG2+1: FIFO occupancy
- `idle` out 1: state IDLE and FIFO empty

## Operation
- Accept: a job is accepted when `job_valid & job_ready`. The FIFO stores {id, size}. `id` comes from a wrapping counter of width ID_WDTH, reset 0, incremented on each accept.
- `job_ready` = !full & state != HALT. There is no push-while-full, even if a pop happens in the same cycle. Push and pop in the same cycle on a non-full FIFO leave `pending` unchanged.
- States: IDLE, START, RUN, RESP, HALT.
- IDLE: if the FIFO is non-empty, pop the head.
  - If size is 0 or > 2^ADDR_WDTH: status=11, go to RESP. The sorter is not touched.
  - Otherwise: load `sort_arr_size`, go to START.
- START: `sort_start`=1 for exactly this cycle. Clear the watchdog. Go to RUN.
- RUN: the watchdog increments each cycle.
  - `sort_done` high: status = `sort_err` ? 01 : 00, go to RESP.
  - Else, if `tmo_limit`!=0 and the watchdog reaches `tmo_limit`: status=10, go to RESP.
  - `sort_done` wins over timeout in the same cycle.
- RESP: hold `res_valid`=1 with stable `res_id`/`res_status` until `res_ready`. On handshake, go to IDLE, or to HALT if status=10.
- HALT: the sorter is presumed hung. No further launches, `job_ready`=0, queued jobs are retained. Leave HALT only via `rst_n`.
- `sort_done`/`sort_err` are ignored outside RUN. The sorter must drop `done` within one cycle of `sort_start`.
- Watchdog saturates at all-ones and does not wrap.

## Timing
- Reset values: `job_ready`=1, `sort_start`=0, `sort_arr_size`=0, `res_valid`=0, `res_id`=0, `res_status`=00, `pending`=0, `idle`=1. State=IDLE, id counter=0, FIFO emptied.
- Assertion of `rst_n` mid-job aborts immediately. Any in-flight result is lost.
- Launch latency: a job accepted into an empty FIFO at edge N gives `sort_start`=1 in cycle N+2. A rejected job gives `res_valid`=1 in cycle N+2.
- Completion latency: `sort_done` sampled at edge M gives `res_valid`=1 in cycle M+1.
- Back-to-back: after the RESP handshake at edge K, the next queued job's `sort_start` rises in cycle K+2.
- Timeout: `tmo_limit`=T gives `res_status`=10 in the cycle after the Tth RUN cycle without `sort_done`.
- All outputs are registered. There are no combinational paths from inputs to outputs, except through `job_ready` (FIFO full flag, registered).

## Configuration
- `SORT_SCHED_TIMEOUT_EN` defined: watchdog counter and timeout behaviour present, as above.
- Not defined:
  - Watchdog logic is removed and `tmo_limit` is ignored.
  - RUN waits indefinitely for `sort_done`.
  - Status 10 is never produced and HALT is unreachable.
  - All other behaviour is identical.

## Test plan
- Single job: push size 5, sorter returns `done` 20 cycles after start.
  - Required: `sort_arr_size`=5, one `sort_start` pulse at N+2, result id=0, status=00.
- Reject: push sizes 0 and 17 (ADDR_WDTH=4).
  - Required: two results, ids 0 and 1, status=11, with `sort_start` never asserted.
- Full FIFO: push 5 jobs while the sorter is busy.
  - Required: `job_ready`=0 after 4 queued, `pending`=4.
  - Required: results return in order with ids 0..4 after draining.
- Error and backpressure: sorter returns `done` with `err`=1 while `res_ready` is held low 3 cycles.
  - Required: status=01 held stable, and the next `sort_start` comes only 2 cycles after the handshake.
- Timeout (macro defined): `tmo_limit`=8, sorter never done.
  - Required: status=10 after 8 RUN cycles, then HALT with `job_ready`=0.
  - Required: `rst_n` pulse restores all reset values.
- Done/timeout collision: `sort_done` on exactly the 8th RUN cycle with `tmo_limit`=8.
  - Required: status=00 and no HALT.

Source files
------------

// File: rtl/sort_job_scheduler.sv
// sort_job_scheduler
//
// Queues sort requests (array sizes) in a small FIFO and runs them one at a
// time on a single sort_circuit. The scheduler checks each size, launches the
// sorter with a one-cycle start pulse, and waits for done/err. It then returns
// one tagged result per job on a valid/ready response port.
//
// Optional feature macro: SORT_SCHED_TIMEOUT_EN
//   defined     : a watchdog is built. A run that reaches tmo_limit cycles
//                 without sort_done reports status 10 and parks the block in
//                 HALT until rst_n.
//   not defined : there is no watchdog. tmo_limit is ignored and RUN waits
//                 for sort_done indefinitely.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   job_valid/job_ready  job offer handshake; job_size is the requested size
//   sort_arr_size        size presented to the sorter
//   sort_start           one-cycle launch pulse to the sorter
//   sort_done/sort_err   sorter completion; err is qualified by done
//   tmo_limit            watchdog limit in cycles (0 disables the watchdog)
//   res_valid/res_ready  result handshake carrying res_id and res_status
//                        (00 ok, 01 sort error, 10 timeout, 11 rejected)
//   pending              FIFO occupancy
//   idle                 IDLE state with an empty FIFO
module sort_job_scheduler #(
    parameter int ADDR_WDTH = 4,
    parameter int FIFO_LOG2 = 2,
    parameter int ID_WDTH   = 4,
    parameter int TMO_WDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_valid,
    input  logic [ADDR_WDTH:0]   job_size,
    output logic                 job_ready,
    output logic [ADDR_WDTH:0]   sort_arr_size,
    output logic                 sort_start,
    input  logic                 sort_done,
    input  logic                 sort_err,
    input  logic [TMO_WDTH-1:0]  tmo_limit,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_WDTH-1:0]   res_id,
    output logic [1:0]           res_status,
    output logic [FIFO_LOG2:0]   pending,
    output logic                 idle
);

    localparam int DEPTH  = 1 << FIFO_LOG2;
    localparam int ENTRYW = ID_WDTH + ADDR_WDTH + 1;

    localparam logic [ADDR_WDTH:0]   MAX_SIZE = {1'b1, {ADDR_WDTH{1'b0}}};
    localparam logic [FIFO_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [FIFO_LOG2:0]   CNT_ONE  = 1;
    localparam logic [ID_WDTH-1:0]   ID_ONE   = 1;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_REJ = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_RESP,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [ENTRYW-1:0]     mem_q [DEPTH];
    logic [FIFO_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_LOG2:0]    count_q, count_d;
    logic [ID_WDTH-1:0]    next_id_q;
    logic [ADDR_WDTH:0]    size_q, size_d;
    logic                  start_q, start_d;
    logic [ID_WDTH-1:0]    id_q, id_d;
    logic [1:0]            status_q, status_d;
    logic                  push, pop;
    logic [ID_WDTH-1:0]    head_id;
    logic [ADDR_WDTH:0]    head_size;

`ifdef SORT_SCHED_TIMEOUT_EN
    localparam logic [TMO_WDTH-1:0] WD_ONE = 1;
    logic [TMO_WDTH-1:0]   wd_q, wd_d, wd_inc;

    // The watchdog saturates instead of wrapping, so a very large limit can
    // never be skipped over.
    assign wd_inc = (wd_q == '1) ? wd_q : wd_q + WD_ONE;
`else
    logic unused_tmo;
    assign unused_tmo = ^tmo_limit;
`endif

    // The occupancy can only reach DEPTH, so its MSB is exactly the full flag.
    assign job_ready = !count_q[FIFO_LOG2] && (state_q != S_HALT);
    assign push      = job_valid && job_ready;
    assign head_id   = mem_q[rd_ptr_q][ENTRYW-1:ADDR_WDTH+1];
    assign head_size = mem_q[rd_ptr_q][ADDR_WDTH:0];

    assign sort_arr_size = size_q;
    assign sort_start    = start_q;
    assign res_valid     = (state_q == S_RESP);
    assign res_id        = id_q;
    assign res_status    = status_q;
    assign pending       = count_q;
    assign idle          = (state_q == S_IDLE) && (count_q == '0);

    // Next-state logic. The head is popped only in IDLE. A bad size skips the
    // sorter and goes straight to RESP. sort_done is honoured only in RUN and
    // takes priority over a timeout in the same cycle.
    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        start_d  = 1'b0;
        id_d     = id_q;
        status_d = status_q;
        pop      = 1'b0;
`ifdef SORT_SCHED_TIMEOUT_EN
        wd_d     = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop  = 1'b1;
                    id_d = head_id;
                    if ((head_size == '0) || (head_size > MAX_SIZE)) begin
                        status_d = ST_REJ;
                        state_d  = S_RESP;
                    end else begin
                        size_d  = head_size;
                        start_d = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
`ifdef SORT_SCHED_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = S_RUN;
            end
            S_RUN: begin
`ifdef SORT_SCHED_TIMEOUT_EN
                wd_d = wd_inc;
`endif
                if (sort_done) begin
                    status_d = sort_err ? ST_ERR : ST_OK;
                    state_d  = S_RESP;
                end
`ifdef SORT_SCHED_TIMEOUT_EN
                else if ((tmo_limit != '0) && (wd_inc >= tmo_limit)) begin
                    status_d = ST_TMO;
                    state_d  = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (res_ready) begin
                    state_d = (status_q == ST_TMO) ? S_HALT : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Occupancy: a push and a pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Job storage: {id, size}. The id comes from the accept counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {next_id_q, job_size};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            next_id_q <= '0;
            size_q    <= '0;
            start_q   <= 1'b0;
            id_q      <= '0;
            status_q  <= ST_OK;
`ifdef SORT_SCHED_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            size_q   <= size_d;
            start_q  <= start_d;
            id_q     <= id_d;
            status_q <= status_d;
`ifdef SORT_SCHED_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + PTR_ONE;
                next_id_q <= next_id_q + ID_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Testbench for sort_job_scheduler (default parameters, ADDR_WDTH=4).
// A behavioural sorter model answers each sort_start with done after a
// programmable number of cycles, or never when the delay is negative.
module tb_sort_job_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic [4:0]  job_size;
    logic        job_ready;
    logic [4:0]  sort_arr_size;
    logic        sort_start;
    logic        sort_done;
    logic        sort_err;
    logic [15:0] tmo_limit;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_id;
    logic [1:0]  res_status;
    logic [2:0]  pending;
    logic        idle;

    int          total = 0;
    int          bad = 0;
    int          sorterDelay = 20;
    bit          sorterErr = 1'b0;
    int          startCount = 0;
    int          doneCnt = 0;
    logic [3:0]  expId = 4'd0;

    typedef struct {
        logic [4:0]  size;
        int          delay;
        bit          err;
        logic [15:0] tmo;
        logic [1:0]  expStatus;
        bit          expStart;
    } vec_t;

    vec_t vecs[8];

    sort_job_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_size      (job_size),
        .job_ready     (job_ready),
        .sort_arr_size (sort_arr_size),
        .sort_start    (sort_start),
        .sort_done     (sort_done),
        .sort_err      (sort_err),
        .tmo_limit     (tmo_limit),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_id        (res_id),
        .res_status    (res_status),
        .pending       (pending),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    // Sorter model, evaluated on the falling edge. After a start pulse it
    // raises done for exactly one cycle, sorterDelay cycles into RUN.
    initial begin
        sort_done = 1'b0;
        sort_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (doneCnt > 0) begin
                doneCnt--;
                if (doneCnt == 0) begin
                    sort_done = 1'b1;
                    sort_err  = sorterErr;
                end
            end else begin
                sort_done = 1'b0;
                sort_err  = 1'b0;
            end
            if (sort_start === 1'b1) begin
                startCount++;
                if (sorterDelay > 0) doneCnt = sorterDelay;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_job_ready"},  job_ready,     1);
        checkOutput({tag, "_sort_start"}, sort_start,    0);
        checkOutput({tag, "_arr_size"},   sort_arr_size, 0);
        checkOutput({tag, "_res_valid"},  res_valid,     0);
        checkOutput({tag, "_res_id"},     res_id,        0);
        checkOutput({tag, "_res_status"}, res_status,    0);
        checkOutput({tag, "_pending"},    pending,       0);
        checkOutput({tag, "_idle"},       idle,          1);
    endtask

    task automatic pushJob(input logic [4:0] size);
        job_size  = size;
        job_valid = 1'b1;
        for (int i = 0; i < 300 && job_ready !== 1'b1; i++) tick();
        checkOutput("push_ready", job_ready, 1);
        tick();
        job_valid = 1'b0;
    endtask

    task automatic waitResValid(input string name);
        for (int i = 0; i < 300 && res_valid !== 1'b1; i++) tick();
        checkOutput(name, res_valid, 1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // One complete job: push it, wait for its result, check it, and consume it.
    task automatic applyStimulus(input vec_t v, input int idx);
        int startsBefore;
        string tag;
        tag          = $sformatf("vec%0d", idx);
        sorterDelay  = v.delay;
        sorterErr    = v.err;
        tmo_limit    = v.tmo;
        startsBefore = startCount;
        pushJob(v.size);
        waitResValid({tag, "_wait"});
        checkOutput({tag, "_id"},     res_id,     expId);
        checkOutput({tag, "_status"}, res_status, v.expStatus);
        checkOutput({tag, "_starts"}, startCount - startsBefore, v.expStart ? 1 : 0);
        if (v.expStart) checkOutput({tag, "_arr_size"}, sort_arr_size, v.size);
        consume();
        checkOutput({tag, "_ready_after"}, job_ready, 1);
        expId++;
    endtask

    initial begin
        int n;
        int snap;
        vec_t extra;

        vecs[0] = '{5'd5,  20, 1'b0, 16'd0,   2'b00, 1'b1};
        vecs[1] = '{5'd0,  5,  1'b0, 16'd0,   2'b11, 1'b0};
        vecs[2] = '{5'd17, 5,  1'b0, 16'd0,   2'b11, 1'b0};
        vecs[3] = '{5'd16, 3,  1'b1, 16'd0,   2'b01, 1'b1};
        vecs[4] = '{5'd1,  1,  1'b0, 16'd0,   2'b00, 1'b1};
        vecs[5] = '{5'd31, 5,  1'b0, 16'd0,   2'b11, 1'b0};
        vecs[6] = '{5'd7,  8,  1'b0, 16'd8,   2'b00, 1'b1};
        vecs[7] = '{5'd9,  2,  1'b1, 16'd100, 2'b01, 1'b1};

        rst_n     = 1'b0;
        job_valid = 1'b0;
        job_size  = 5'd0;
        res_ready = 1'b0;
        tmo_limit = 16'd0;
        tick();
        tick();
        checkResetValues("reset");
        rst_n = 1'b1;
        tick();

        // Launch and completion latency for a single job of size 5.
        sorterDelay = 20;
        sorterErr   = 1'b0;
        snap        = startCount;
        pushJob(5'd5);
        checkOutput("lat_start_n1", sort_start, 0);
        checkOutput("lat_pending",  pending,    1);
        tick();
        checkOutput("lat_start_n2", sort_start,    1);
        checkOutput("lat_arr_size", sort_arr_size, 5);
        n = 0;
        for (int i = 0; i < 100 && res_valid !== 1'b1; i++) begin
            tick();
            n++;
        end
        checkOutput("lat_done_to_res", n, 21);
        checkOutput("lat_id",     res_id,     0);
        checkOutput("lat_status", res_status, 0);
        checkOutput("lat_starts", startCount - snap, 1);
        consume();
        expId++;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // Full FIFO: one job running plus four queued; a fifth queued offer
        // must be refused.
        sorterDelay = 30;
        sorterErr   = 1'b0;
        tmo_limit   = 16'd0;
        pushJob(5'd3);
        sorterDelay = 2;
        for (int i = 0; i < 4; i++) pushJob(5'd4 + 5'(i));
        checkOutput("full_pending",   pending,   4);
        checkOutput("full_job_ready", job_ready, 0);
        job_size  = 5'd8;
        job_valid = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("full_hold_pending", pending,   4);
        checkOutput("full_hold_ready",   job_ready, 0);
        job_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            waitResValid($sformatf("drain%0d_wait", i));
            checkOutput($sformatf("drain%0d_id", i),     res_id,     expId);
            checkOutput($sformatf("drain%0d_status", i), res_status, 0);
            consume();
            expId++;
        end

        // Sorter error with the response held off for 3 cycles, then the
        // queued job launches two cycles after the handshake.
        sorterDelay = 4;
        sorterErr   = 1'b1;
        pushJob(5'd6);
        pushJob(5'd2);
        waitResValid("bp_wait");
        checkOutput("bp_status", res_status, 1);
        checkOutput("bp_id",     res_id,     expId);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("bp_hold%0d", i), {res_valid, res_id, res_status}, {1'b1, expId, 2'b01});
        end
        sorterErr = 1'b0;
        expId++;
        consume();
        checkOutput("bp_k1_start", sort_start, 0);
        tick();
        checkOutput("bp_k2_start", sort_start,    1);
        checkOutput("bp_k2_size",  sort_arr_size, 2);
        waitResValid("bp2_wait");
        checkOutput("bp2_id",     res_id,     expId);
        checkOutput("bp2_status", res_status, 0);
        consume();
        expId++;

`ifdef SORT_SCHED_TIMEOUT_EN
        // Hung sorter: timeout after 8 RUN cycles, then HALT with the queued
        // job retained, until a reset.
        tmo_limit   = 16'd8;
        sorterDelay = -1;
        pushJob(5'd11);
        pushJob(5'd4);
        for (int i = 0; i < 50 && sort_start !== 1'b1; i++) tick();
        checkOutput("tmo_start_seen", sort_start, 1);
        n = 0;
        for (int i = 0; i < 100 && res_valid !== 1'b1; i++) begin
            tick();
            n++;
        end
        checkOutput("tmo_cycles", n, 9);
        checkOutput("tmo_status", res_status, 2);
        checkOutput("tmo_id",     res_id,     expId);
        consume();
        snap = startCount;
        tick();
        tick();
        tick();
        checkOutput("halt_job_ready", job_ready, 0);
        checkOutput("halt_pending",   pending,   1);
        checkOutput("halt_idle",      idle,      0);
        checkOutput("halt_res_valid", res_valid, 0);
        checkOutput("halt_no_start",  startCount - snap, 0);
        rst_n = 1'b0;
        #2;
        checkResetValues("halt_reset");
        tick();
        rst_n = 1'b1;
        tick();
        expId = 4'd0;
        extra = '{5'd2, 3, 1'b0, 16'd0, 2'b00, 1'b1};
        applyStimulus(extra, 100);
`else
        // Without the watchdog a limit of 8 has no effect on a 12-cycle sort.
        extra = '{5'd8, 12, 1'b0, 16'd8, 2'b00, 1'b1};
        applyStimulus(extra, 100);
        rst_n = 1'b0;
        #2;
        checkResetValues("end_reset");
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
